// File: rtl/link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : link_arbiter
//  Description : Round-robin arbiter sharing one valid/ready link between
//                NUM_REQ requesters, with a bounded burst per grant.
//                Optional statistics counters are enabled by defining
//                LINK_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module link_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  parameter int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      grant_valid,
  output logic [GW-1:0]             grant_id
`ifdef LINK_ARB_STATS_EN
  ,
  output logic [31:0]               stat_beats,
  output logic [15:0]               stat_grants
`endif
);

  localparam int c_cw = $clog2(BURST_MAX + 1);
  localparam logic [c_cw-1:0] c_last_beat = c_cw'(BURST_MAX - 1);
  localparam logic [GW-1:0]   c_last_req  = GW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [GW-1:0]       r_ptr, w_ptr_nxt;
  logic [GW-1:0]       r_grant_id, w_grant_id_nxt;
  logic [c_cw-1:0]     r_beat_cnt, w_beat_cnt_nxt;
  logic [GW-1:0]       w_winner, w_scan_idx;
  logic                w_found;
  logic                w_sel_valid;
  logic [DATA_W-1:0]   w_sel_data;
  logic [NUM_REQ-1:0]  w_sel_onehot;
  logic                w_xfer;

  // Select the lane of the currently granted requester.
  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_data   = '0;
    w_sel_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GW'(i)) begin
        w_sel_valid     = req_valid[i];
        w_sel_data      = req_data[i*DATA_W +: DATA_W];
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  // Round-robin scan: first valid requester starting at ptr, wrapping.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan_idx = GW'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req_valid[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end

  // Outputs are decoded from state so an async reset clears them at once.
  assign grant_valid = (r_state == ST_GRANT);
  assign grant_id    = r_grant_id;
  assign out_valid   = grant_valid & w_sel_valid;
  assign out_data    = grant_valid ? w_sel_data : '0;
  assign req_ready   = (grant_valid && out_ready) ? w_sel_onehot : '0;
  assign w_xfer      = out_valid & out_ready;

  // Next-state logic: grant on request, release on burst end or valid drop.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_id_nxt = r_grant_id;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_id_nxt = w_winner;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!w_sel_valid || (w_xfer && (r_beat_cnt == c_last_beat))) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = (r_grant_id == c_last_req) ? '0 : r_grant_id + GW'(1);
        end
        if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + c_cw'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

`ifdef LINK_ARB_STATS_EN
  logic [31:0] r_stat_beats;
  logic [15:0] r_stat_grants;

  // Free-running transfer and grant counters; wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_beats  <= '0;
      r_stat_grants <= '0;
    end else begin
      if (w_xfer) begin
        r_stat_beats <= r_stat_beats + 32'd1;
      end
      if ((r_state == ST_IDLE) && w_found) begin
        r_stat_grants <= r_stat_grants + 16'd1;
      end
    end
  end

  assign stat_beats  = r_stat_beats;
  assign stat_grants = r_stat_grants;
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_link_arbiter
//  Description : Directed self-checking bench for link_arbiter
//                (NUM_REQ=4, DATA_W=8, BURST_MAX=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_link_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_ready;
  logic                      grant_valid;
  logic [1:0]                grant_id;
`ifdef LINK_ARB_STATS_EN
  logic [31:0]               stat_beats;
  logic [15:0]               stat_grants;
`endif

  logic [7:0] dat [NUM_REQ];
  int vec_cnt = 0;
  int err_cnt = 0;

  link_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
`ifdef LINK_ARB_STATS_EN
    ,
    .stat_beats  (stat_beats),
    .stat_grants (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  // Each requester presents its own running data value.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = dat[i];
  end

  // Advance one clock; a requester that was accepted moves to its next beat.
  task automatic adv();
    logic [NUM_REQ-1:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (hs[i]) dat[i] = dat[i] + 8'd1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) dat[i] = 8'hAA;
    @(negedge clk);
    vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vec_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    vec_cnt++; if (grant_id !== 2'd0) begin err_cnt++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    vec_cnt++; if (out_data !== 8'h00) begin err_cnt++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    dat[2] = 8'h10;
    out_ready = 1'b1;
    req_valid = 4'b0100;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      vec_cnt++; if (grant_valid !== 1'b0 || out_valid !== 1'b0 || req_ready !== 4'b0000) begin
        err_cnt++; $display("FAIL single_idle%0d: got gv=%b ov=%b rr=%b want 0 0 0000", b, grant_valid, out_valid, req_ready);
      end
      adv();
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        vec_cnt++; if (grant_valid !== 1'b1 || grant_id !== 2'd2 || out_valid !== 1'b1 || req_ready !== 4'b0100
                       || out_data !== 8'(8'h10 + 4*b + k)) begin
          err_cnt++; $display("FAIL single_beat%0d_%0d: got gv=%b id=%0d ov=%b rr=%b d=%h want 1 2 1 0100 %h",
                              b, k, grant_valid, grant_id, out_valid, req_ready, out_data, 8'(8'h10 + 4*b + k));
        end
        adv();
      end
    end
    @(negedge clk);
    vec_cnt++; if (grant_valid !== 1'b0 || grant_id !== 2'd2) begin
      err_cnt++; $display("FAIL single_hold_id: got gv=%b id=%0d want 0 2", grant_valid, grant_id);
    end
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) dat[i] = 8'(i * 32);
    out_ready = 1'b1;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_idle%0d: got gv=%b want 0", n, grant_valid); end
      adv();
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        vec_cnt++; if (grant_valid !== 1'b1 || grant_id !== 2'(seq[n]) || req_ready !== 4'(1 << seq[n])
                       || out_data !== 8'(seq[n] * 32 + (n == 4 ? 4 : 0) + k)) begin
          err_cnt++; $display("FAIL rr_grant%0d_beat%0d: got gv=%b id=%0d rr=%b d=%h want 1 %0d %b %h", n, k,
                              grant_valid, grant_id, req_ready, out_data, seq[n], 4'(1 << seq[n]),
                              8'(seq[n] * 32 + (n == 4 ? 4 : 0) + k));
        end
        adv();
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dat[1] = 8'h30;
    out_ready = 1'b1;
    req_valid = 4'b0010;
    adv();                       // IDLE -> GRANT(1)
    @(negedge clk);
    vec_cnt++; if (out_data !== 8'h30 || req_ready !== 4'b0010) begin
      err_cnt++; $display("FAIL bp_first: got d=%h rr=%b want 30 0010", out_data, req_ready);
    end
    adv();                       // beat 0x30 transfers
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      vec_cnt++; if (out_data !== 8'h31 || out_valid !== 1'b1 || req_ready !== 4'b0000 || grant_valid !== 1'b1) begin
        err_cnt++; $display("FAIL bp_stall%0d: got d=%h ov=%b rr=%b gv=%b want 31 1 0000 1",
                            s, out_data, out_valid, req_ready, grant_valid);
      end
      adv();
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      vec_cnt++; if (out_data !== 8'(8'h30 + k) || req_ready !== 4'b0010 || grant_valid !== 1'b1) begin
        err_cnt++; $display("FAIL bp_resume%0d: got d=%h rr=%b gv=%b want %h 0010 1",
                            k, out_data, req_ready, grant_valid, 8'(8'h30 + k));
      end
      adv();
    end
    @(negedge clk);
    vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_release: got gv=%b want 0", grant_valid); end
  endtask

  task automatic test_early_release();
    do_reset();
    dat[0] = 8'h80;
    dat[1] = 8'h90;
    dat[3] = 8'h70;
    out_ready = 1'b1;
    req_valid = 4'b1000;
    adv();                       // grant to 3
    req_valid = 4'b1011;         // late requests are ignored during GRANT
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vec_cnt++; if (grant_id !== 2'd3 || out_data !== 8'(8'h70 + k) || req_ready !== 4'b1000) begin
        err_cnt++; $display("FAIL er_beat%0d: got id=%0d d=%h rr=%b want 3 %h 1000", k, grant_id, out_data, req_ready, 8'(8'h70 + k));
      end
      adv();
    end
    req_valid = 4'b0011;
    @(negedge clk);
    vec_cnt++; if (out_valid !== 1'b0 || grant_valid !== 1'b1) begin
      err_cnt++; $display("FAIL er_drop: got ov=%b gv=%b want 0 1", out_valid, grant_valid);
    end
    adv();
    @(negedge clk);
    vec_cnt++; if (grant_valid !== 1'b0 || grant_id !== 2'd3 || dat[3] !== 8'h72) begin
      err_cnt++; $display("FAIL er_idle: got gv=%b id=%0d d3=%h want 0 3 72", grant_valid, grant_id, dat[3]);
    end
    adv();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vec_cnt++; if (grant_id !== 2'd0 || out_data !== 8'(8'h80 + k)) begin
        err_cnt++; $display("FAIL er_g0_%0d: got id=%0d d=%h want 0 %h", k, grant_id, out_data, 8'(8'h80 + k));
      end
      adv();
    end
    adv();                       // IDLE
    @(negedge clk);
    vec_cnt++; if (grant_valid !== 1'b1 || grant_id !== 2'd1 || out_data !== 8'h90) begin
      err_cnt++; $display("FAIL er_g1: got gv=%b id=%0d d=%h want 1 1 90", grant_valid, grant_id, out_data);
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    dat[0] = 8'h00;
    dat[2] = 8'h50;
    out_ready = 1'b1;
    req_valid = 4'b0100;
    adv();                       // grant to 2
    adv();                       // 0x50 transfers
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++; if (out_valid !== 1'b0 || req_ready !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      err_cnt++; $display("FAIL mid_reset: got ov=%b rr=%b gv=%b id=%0d want 0 0000 0 0", out_valid, req_ready, grant_valid, grant_id);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    vec_cnt++; if (dat[2] !== 8'h51) begin err_cnt++; $display("FAIL mid_no_xfer: got d2=%h want 51", dat[2]); end
    req_valid = 4'b0101;
    @(negedge clk);
    vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_idle: got gv=%b want 0", grant_valid); end
    adv();
    @(negedge clk);
    vec_cnt++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      err_cnt++; $display("FAIL mid_tie: got gv=%b id=%0d want 1 0", grant_valid, grant_id);
    end
  endtask

`ifdef LINK_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 40; c++) adv();
    vec_cnt++; if (stat_beats !== 32'd32 || stat_grants !== 16'd8) begin
      err_cnt++; $display("FAIL stats: got beats=%0d grants=%0d want 32 8", stat_beats, stat_grants);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_reset_midburst();
`ifdef LINK_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
